// File: rtl/mem_arbiter_if.sv
// Requester/memory bundle of the memory arbiter.
// The arbiter connects through the slave modport, the environment through master.
// arb_state mirrors the arbiter FSM state (0 IDLE, 1 ISSUE, 2 RESP) for observation.
// Handshake: a requester raises *_req and holds it and its payload until *_gnt is
// seen high in the same cycle; the grant is the acceptance, and one *_rvalid pulse
// follows later. On the memory side mem_req and all mem_* fields stay stable until
// the cycle in which mem_ready is high.
interface mem_arbiter_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
);
  logic                     if_req;
  logic [ADDRESS_WIDTH-1:0] if_addr;
  logic                     if_gnt;
  logic                     if_rvalid;
  logic [DATA_WIDTH-1:0]    if_rdata;
  logic                     d_req;
  logic                     d_we;
  logic [ADDRESS_WIDTH-1:0] d_addr;
  logic [DATA_WIDTH-1:0]    d_wdata;
  logic [3:0]               d_be;
  logic                     d_gnt;
  logic                     d_rvalid;
  logic [DATA_WIDTH-1:0]    d_rdata;
  logic                     rsp_err;
  logic                     mem_req;
  logic                     mem_we;
  logic [ADDRESS_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0]    mem_wdata;
  logic [3:0]               mem_be;
  logic [DATA_WIDTH-1:0]    mem_rdata;
  logic                     mem_ready;
  logic [1:0]               arb_state;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_rdata, mem_ready,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata, rsp_err,
           mem_req, mem_we, mem_addr, mem_wdata, mem_be, arb_state
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_rdata, mem_ready,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata, rsp_err,
           mem_req, mem_we, mem_addr, mem_wdata, mem_be, arb_state
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shared single-port memory arbiter between instruction fetch and load/store.
// One transaction at a time: IDLE (grant) -> ISSUE (memory handshake) -> RESP.
// Optional macro ARB_ROUND_ROBIN_EN replaces fixed data priority plus fetch
// starvation override with round-robin between the two requesters.
module mem_arbiter #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int MAX_WAIT      = 4,
  parameter int TIMEOUT       = 16
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_D  = 1'b1;
  localparam int   TW     = $clog2(TIMEOUT + 1);

  state_t                   state_q, state_d;
  logic                     gnt_if, gnt_d;
  logic                     owner_q;
  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic                     we_q;
  logic [DATA_WIDTH-1:0]    wdata_q;
  logic [3:0]               be_q;
  logic [DATA_WIDTH-1:0]    if_rdata_q, d_rdata_q, rsp_data;
  logic                     err_q;
  logic [TW-1:0]            timeout_cnt;
  logic                     timeout_hit;
  logic                     issue_end;

`ifndef ARB_ROUND_ROBIN_EN
  localparam int WW = $clog2(MAX_WAIT + 1);
  logic [WW-1:0] wait_cnt;

  // Grant decision: data first unless fetch has been denied MAX_WAIT cycles.
  always_comb begin
    gnt_if = 1'b0;
    gnt_d  = 1'b0;
    if (state_q == IDLE) begin
      if (bus.if_req && (wait_cnt >= WW'(MAX_WAIT))) gnt_if = 1'b1;
      else if (bus.d_req)                            gnt_d  = 1'b1;
      else if (bus.if_req)                           gnt_if = 1'b1;
    end
  end

  // Fetch starvation counter: counts denied cycles, saturating, cleared otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (bus.if_req && !gnt_if) begin
      if (wait_cnt != WW'(MAX_WAIT)) wait_cnt <= wait_cnt + 1'b1;
    end else begin
      wait_cnt <= '0;
    end
  end
`else
  // Grant decision: round-robin on contention, owner_q is the last served.
  always_comb begin
    gnt_if = 1'b0;
    gnt_d  = 1'b0;
    if (state_q == IDLE) begin
      if (bus.if_req && bus.d_req) begin
        if (owner_q == OWN_IF) gnt_d  = 1'b1;
        else                   gnt_if = 1'b1;
      end else if (bus.d_req) begin
        gnt_d = 1'b1;
      end else if (bus.if_req) begin
        gnt_if = 1'b1;
      end
    end
  end
`endif

  assign timeout_hit = !bus.mem_ready && (timeout_cnt == TW'(TIMEOUT - 1));
  assign issue_end   = (state_q == ISSUE) && (bus.mem_ready || timeout_hit);
  assign rsp_data    = (bus.mem_ready && !we_q) ? bus.mem_rdata : '0;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (gnt_if || gnt_d) state_d = ISSUE;
      ISSUE:   if (issue_end)       state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Capture the granted request; fetches are always full-word reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      be_q    <= 4'b0000;
      owner_q <= OWN_IF;
    end else if (gnt_d) begin
      addr_q  <= bus.d_addr;
      we_q    <= bus.d_we;
      wdata_q <= bus.d_wdata;
      be_q    <= bus.d_be;
      owner_q <= OWN_D;
    end else if (gnt_if) begin
      addr_q  <= bus.if_addr;
      we_q    <= 1'b0;
      wdata_q <= '0;
      be_q    <= 4'b1111;
      owner_q <= OWN_IF;
    end
  end

  // Issue-cycle counter, running only while waiting on the memory.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    timeout_cnt <= '0;
    else if (state_q == ISSUE)  timeout_cnt <= timeout_cnt + 1'b1;
    else                        timeout_cnt <= '0;
  end

  // Response capture at the end of ISSUE; rdata holds until the owner's next response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      err_q      <= 1'b0;
    end else if (issue_end) begin
      if (owner_q == OWN_D) d_rdata_q  <= rsp_data;
      else                  if_rdata_q <= rsp_data;
      err_q <= !bus.mem_ready;
    end
  end

  assign bus.if_gnt    = gnt_if;
  assign bus.d_gnt     = gnt_d;
  assign bus.if_rvalid = (state_q == RESP) && (owner_q == OWN_IF);
  assign bus.d_rvalid  = (state_q == RESP) && (owner_q == OWN_D);
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.rsp_err   = (state_q == RESP) && err_q;
  assign bus.mem_req   = (state_q == ISSUE);
  assign bus.mem_we    = (state_q == ISSUE) && we_q;
  assign bus.mem_addr  = (state_q == ISSUE) ? addr_q  : '0;
  assign bus.mem_wdata = (state_q == ISSUE) ? wdata_q : '0;
  assign bus.mem_be    = (state_q == ISSUE) ? be_q    : 4'b0000;
  assign bus.arb_state = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: reset state, directed table of single transactions,
// contention, asynchronous reset mid-transaction, and randomized traffic against
// a transaction-level reference model.
module tb_mem_arbiter;
  localparam int AW       = 32;
  localparam int DW       = 32;
  localparam int MAX_WAIT = 4;
  localparam int TIMEOUT  = 16;
  localparam int NEVER    = 99;

  // Clock and reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  mem_arbiter #(
    .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .MAX_WAIT(MAX_WAIT), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Scoreboard for the randomized phase: {is_d, err, data} with due cycle.
  logic [DW+1:0] exp_q[$];
  int            exp_t[$];
  logic [31:0]   ref_mem[logic [31:0]];
  logic [31:0]   dev_mem[logic [31:0]];

  typedef struct {
    logic        is_d;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          lat;
    logic [31:0] rdata;
    logic        exp_err;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = nw[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  // Driver tasks
  task automatic drive_quiet();
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0; bus.d_be = 4'b0000;
    bus.mem_ready = 1'b0; bus.mem_rdata = '0;
  endtask

  task automatic apply_reset();
    drive_quiet();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One isolated transaction: grant, ISSUE with latency v.lat, RESP, back to IDLE.
  // Both requests are held high during ISSUE to show no grant happens there.
  task automatic run_vec(input vec_t v, input int idx);
    bit done;
    string s;
    s = $sformatf("v%0d", idx);
    @(negedge clk);
    bus.if_req = !v.is_d; bus.if_addr = v.addr;
    bus.d_req = v.is_d; bus.d_we = v.we; bus.d_addr = v.addr;
    bus.d_wdata = v.wdata; bus.d_be = v.be;
    #1;
    check({s, "_if_gnt"}, 32'(bus.if_gnt), 32'(!v.is_d));
    check({s, "_d_gnt"}, 32'(bus.d_gnt), 32'(v.is_d));
    @(posedge clk);
    done = 1'b0;
    for (int c = 0; c < TIMEOUT && !done; c++) begin
      @(negedge clk);
      bus.if_req = 1'b1; bus.d_req = 1'b1;
      #1;
      check({s, "_mem_req"}, 32'(bus.mem_req), 32'd1);
      check({s, "_mem_addr"}, bus.mem_addr, v.addr);
      check({s, "_mem_we"}, 32'(bus.mem_we), 32'(v.is_d && v.we));
      check({s, "_mem_be"}, 32'(bus.mem_be), v.is_d ? 32'(v.be) : 32'hF);
      if (v.is_d && v.we) check({s, "_mem_wdata"}, bus.mem_wdata, v.wdata);
      check({s, "_busy_gnt"}, 32'({bus.if_gnt, bus.d_gnt}), 32'd0);
      if (c == v.lat) begin
        bus.mem_ready = 1'b1; bus.mem_rdata = v.rdata; done = 1'b1;
      end else begin
        bus.mem_ready = 1'b0; bus.mem_rdata = $urandom;
      end
      @(posedge clk);
    end
    @(negedge clk);
    bus.mem_ready = 1'b0; bus.if_req = 1'b0; bus.d_req = 1'b0;
    #1;
    check({s, "_resp_mem_req"}, 32'(bus.mem_req), 32'd0);
    check({s, "_if_rvalid"}, 32'(bus.if_rvalid), 32'(!v.is_d));
    check({s, "_d_rvalid"}, 32'(bus.d_rvalid), 32'(v.is_d));
    check({s, "_rdata"}, v.is_d ? bus.d_rdata : bus.if_rdata, v.exp_data);
    check({s, "_rsp_err"}, 32'(bus.rsp_err), 32'(v.exp_err));
    @(negedge clk);
    #1;
    check({s, "_pulse_end"}, 32'({bus.if_rvalid, bus.d_rvalid}), 32'd0);
    check({s, "_state_idle"}, 32'(bus.arb_state), 32'd0);
    check({s, "_rdata_hold"}, v.is_d ? bus.d_rdata : bus.if_rdata, v.exp_data);
  endtask

  // Both requesters held, memory always ready: record the first eight grants.
  task automatic run_contention();
    byte   got[$];
    string exp_s;
`ifdef ARB_ROUND_ROBIN_EN
    exp_s = "DIDIDIDI";
`else
    exp_s = "DDIDIDID";
`endif
    apply_reset();
    bus.if_req = 1'b1; bus.if_addr = 32'h400;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h800; bus.d_be = 4'hF;
    bus.mem_ready = 1'b1; bus.mem_rdata = 32'h1111_2222;
    for (int c = 0; c < 80 && got.size() < 8; c++) begin
      #1;
      if (bus.if_gnt && bus.d_gnt) check("cont_double_gnt", 32'd1, 32'd0);
      else if (bus.d_gnt) got.push_back("D");
      else if (bus.if_gnt) got.push_back("I");
      @(negedge clk);
    end
    check("cont_grant_count", 32'(got.size()), 32'd8);
    for (int i = 0; i < 8 && i < got.size(); i++)
      check($sformatf("cont_grant%0d", i), 32'(got[i]), 32'(exp_s[i]));
    bus.if_req = 1'b0; bus.d_req = 1'b0;
    repeat (4) @(negedge clk);
    bus.mem_ready = 1'b0;
  endtask

  // Asynchronous reset in the middle of ISSUE, then a normal transaction.
  task automatic run_reset_mid();
    @(negedge clk);
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h80; bus.d_be = 4'hF;
    @(posedge clk);
    #1 bus.d_req = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    check("rm_before_mem_req", 32'(bus.mem_req), 32'd1);
    rst = 1'b1;
    #1;
    check("rm_mem_req_drop", 32'(bus.mem_req), 32'd0);
    check("rm_state", 32'(bus.arb_state), 32'd0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (c == 2) rst = 1'b0;
      #1;
      check("rm_no_rvalid", 32'({bus.if_rvalid, bus.d_rvalid}), 32'd0);
    end
    run_vec(vecs[0], 100);
  endtask

  // Randomized traffic against a transaction-level model: each grant books the
  // arbiter for (issue cycles + 1) cycles, issue cycles = lat+1 or TIMEOUT.
  task automatic run_random(input int ncyc);
    int          next_idle, cur_g, cur_n, cur_lat, wcnt;
    bit          if_pend, d_pend, drop_if, drop_d, last_d, in_issue, e_if, e_d, err;
    logic [31:0] cur_addr, cur_wdata, a, data;
    logic [3:0]  cur_be;
    logic        cur_we;
    logic [DW+1:0] e;
    apply_reset();
    next_idle = 0; cur_g = -100; cur_n = 0; cur_lat = 0; wcnt = 0;
    if_pend = 0; d_pend = 0; drop_if = 0; drop_d = 0; last_d = 0;
    cur_addr = '0; cur_wdata = '0; cur_be = '0; cur_we = 1'b0;
    for (int t = 0; t < ncyc; t++) begin
      @(negedge clk);
      // response scoreboard
      if (exp_t.size() > 0 && exp_t[0] == t) begin
        e = exp_q.pop_front();
        void'(exp_t.pop_front());
        check("rnd_if_rvalid", 32'(bus.if_rvalid), 32'(!e[DW+1]));
        check("rnd_d_rvalid", 32'(bus.d_rvalid), 32'(e[DW+1]));
        check("rnd_rdata", e[DW+1] ? bus.d_rdata : bus.if_rdata, e[DW-1:0]);
        check("rnd_rsp_err", 32'(bus.rsp_err), 32'(e[DW]));
      end else begin
        check("rnd_no_rvalid", 32'({bus.if_rvalid, bus.d_rvalid}), 32'd0);
      end
      // memory side and device responder
      in_issue = (t > cur_g) && (t <= cur_g + cur_n);
      check("rnd_mem_req", 32'(bus.mem_req), 32'(in_issue));
      bus.mem_ready = 1'b0;
      bus.mem_rdata = $urandom;
      if (in_issue) begin
        check("rnd_mem_addr", bus.mem_addr, cur_addr);
        check("rnd_mem_we", 32'(bus.mem_we), 32'(cur_we));
        check("rnd_mem_be", 32'(bus.mem_be), 32'(cur_be));
        if (cur_we) check("rnd_mem_wdata", bus.mem_wdata, cur_wdata);
        if (cur_lat < TIMEOUT && t == cur_g + 1 + cur_lat) begin
          bus.mem_ready = 1'b1;
          a = bus.mem_addr;
          if (!dev_mem.exists(a)) dev_mem[a] = init_word(a);
          if (bus.mem_we) dev_mem[a] = merge(dev_mem[a], bus.mem_wdata, bus.mem_be);
          else            bus.mem_rdata = dev_mem[a];
        end
      end else begin
        bus.mem_ready = 1'($urandom_range(0, 1));
      end
      // requesters hold until granted, then may re-request later
      if (drop_if) begin bus.if_req = 1'b0; if_pend = 0; drop_if = 0; end
      if (drop_d)  begin bus.d_req = 1'b0;  d_pend = 0;  drop_d = 0;  end
      if (!if_pend && t < ncyc - 40 && $urandom_range(0, 2) == 0) begin
        if_pend = 1; bus.if_req = 1'b1;
        bus.if_addr = 32'h1000 + {26'd0, 4'($urandom_range(0, 15)), 2'b00};
      end
      if (!d_pend && t < ncyc - 40 && $urandom_range(0, 2) == 0) begin
        d_pend = 1; bus.d_req = 1'b1;
        bus.d_we = 1'($urandom_range(0, 1));
        bus.d_addr = 32'h1000 + {26'd0, 4'($urandom_range(0, 15)), 2'b00};
        bus.d_wdata = $urandom;
        bus.d_be = 4'($urandom_range(1, 15));
      end
      #1;
      // expected grant from the arbitration rules
      e_if = 0; e_d = 0;
      if (t >= next_idle) begin
`ifdef ARB_ROUND_ROBIN_EN
        if (bus.if_req && bus.d_req) begin
          if (last_d) e_if = 1; else e_d = 1;
        end else if (bus.d_req) e_d = 1;
        else if (bus.if_req) e_if = 1;
`else
        if (bus.if_req && wcnt >= MAX_WAIT) e_if = 1;
        else if (bus.d_req) e_d = 1;
        else if (bus.if_req) e_if = 1;
`endif
      end
      check("rnd_if_gnt", 32'(bus.if_gnt), 32'(e_if));
      check("rnd_d_gnt", 32'(bus.d_gnt), 32'(e_d));
      if (bus.if_req && !e_if) wcnt = (wcnt < MAX_WAIT) ? wcnt + 1 : MAX_WAIT;
      else                     wcnt = 0;
      if (e_if || e_d) begin
        cur_lat = ($urandom_range(0, 9) == 0) ? NEVER : $urandom_range(0, 4);
        cur_n = (cur_lat < TIMEOUT) ? cur_lat + 1 : TIMEOUT;
        cur_g = t;
        next_idle = t + cur_n + 2;
        err = (cur_lat >= TIMEOUT);
        if (e_d) begin
          cur_addr = bus.d_addr; cur_we = bus.d_we; cur_wdata = bus.d_wdata; cur_be = bus.d_be;
          drop_d = 1; last_d = 1;
        end else begin
          cur_addr = bus.if_addr; cur_we = 1'b0; cur_wdata = '0; cur_be = 4'hF;
          drop_if = 1; last_d = 0;
        end
        if (!ref_mem.exists(cur_addr)) ref_mem[cur_addr] = init_word(cur_addr);
        data = '0;
        if (!err) begin
          if (cur_we) ref_mem[cur_addr] = merge(ref_mem[cur_addr], cur_wdata, cur_be);
          else        data = ref_mem[cur_addr];
        end
        exp_q.push_back({e_d, err, data});
        exp_t.push_back(t + cur_n + 1);
      end
    end
    check("rnd_scoreboard_empty", 32'(exp_q.size()), 32'd0);
    drive_quiet();
  endtask

  initial begin
    vecs[0] = '{1'b0, 1'b0, 32'h100,  32'h0,        4'hF, 0,     32'h0000_0013, 1'b0, 32'h0000_0013};
    vecs[1] = '{1'b1, 1'b1, 32'h2004, 32'hDEADBEEF, 4'h3, 0,     32'h5555_5555, 1'b0, 32'h0};
    vecs[2] = '{1'b1, 1'b0, 32'h3000, 32'h0,        4'hF, 2,     32'hCAFE_F00D, 1'b0, 32'hCAFE_F00D};
    vecs[3] = '{1'b1, 1'b0, 32'h40,   32'h0,        4'hF, NEVER, 32'h7777_7777, 1'b1, 32'h0};
    vecs[4] = '{1'b0, 1'b0, 32'h200,  32'h0,        4'hF, 4,     32'h1234_5678, 1'b0, 32'h1234_5678};
    vecs[5] = '{1'b1, 1'b0, 32'h44,   32'h0,        4'hF, TIMEOUT-1, 32'h0BAD_F00D, 1'b0, 32'h0BAD_F00D};
    vecs[6] = '{1'b1, 1'b1, 32'h48,   32'hA5A5A5A5, 4'hC, NEVER, 32'h0,         1'b1, 32'h0};
    vecs[7] = '{1'b0, 1'b0, 32'h300,  32'h0,        4'hF, NEVER, 32'h9999_9999, 1'b1, 32'h0};

    apply_reset();
    #1;
    check("rst_state", 32'(bus.arb_state), 32'd0);
    check("rst_gnt", 32'({bus.if_gnt, bus.d_gnt}), 32'd0);
    check("rst_rvalid", 32'({bus.if_rvalid, bus.d_rvalid}), 32'd0);
    check("rst_if_rdata", bus.if_rdata, 32'd0);
    check("rst_d_rdata", bus.d_rdata, 32'd0);
    check("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
    check("rst_mem_req", 32'({bus.mem_req, bus.mem_we}), 32'd0);
    check("rst_mem_addr", bus.mem_addr, 32'd0);
    check("rst_mem_wdata", bus.mem_wdata, 32'd0);
    check("rst_mem_be", 32'(bus.mem_be), 32'd0);

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);
    run_contention();
    run_reset_mid();
    run_random(2000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Arbitrates one shared single-ported memory between the instruction-fetch requester and the load/store requester.
- Sits between the fetch/LSU stages of the RV32 core and the unified memory.
- Registers each granted request, drives the memory handshake, and returns a registered response to the owning requester.
- Includes anti-starvation for fetch and a memory-timeout error path.

Parameters:
- ADDRESS_WIDTH, 32, byte address width on all ports.
- DATA_WIDTH, 32, word width of read/write data.
- MAX_WAIT, 4, consecutive cycles fetch may be denied before it is forced to win.
- TIMEOUT, 16, cycles in ISSUE without mem_ready before the transaction aborts with error.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- if_req  in  1  fetch request.
- if_addr  in  ADDRESS_WIDTH  fetch byte address.
- if_gnt  out  1  fetch accepted this cycle (combinational).
- if_rvalid  out  1  fetch response valid, 1-cycle pulse.
- if_rdata  out  DATA_WIDTH  fetch read data.
- d_req  in  1  data request.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDRESS_WIDTH  data byte address.
- d_wdata  in  DATA_WIDTH  store data.
- d_be  in  4  byte enables.
- d_gnt  out  1  data accepted this cycle (combinational).
- d_rvalid  out  1  data response valid, 1-cycle pulse; also pulses for stores.
- d_rdata  out  DATA_WIDTH  load data; 0 for stores.
- rsp_err  out  1  qualifies the current rvalid pulse: transaction timed out.
- mem_req  out  1  memory request, held until mem_ready.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDRESS_WIDTH  memory byte address.
- mem_wdata  out  DATA_WIDTH  memory write data.
- mem_be  out  4  memory byte enables.
- mem_rdata  in  DATA_WIDTH  memory read data, valid with mem_ready.
- mem_ready  in  1  memory completes the request this cycle.

Behaviour:
- Reset (asynchronous, active-high rst) clears every register immediately:
  - state = IDLE.
  - all outputs 0, including mem_*, rvalid, rdata and rsp_err.
  - wait_cnt = 0, timeout_cnt = 0, owner = IF.
- State machine: IDLE -> ISSUE -> RESP -> IDLE.
- IDLE, grant decision:
  - Grants are asserted only in IDLE, and at most one grant per cycle.
  - Default priority is data over fetch.
  - Fetch wins if wait_cnt >= MAX_WAIT.
  - On a grant, the address, we, wdata, be and owner are captured into registers and the state moves to ISSUE.
  - Fetch grants capture we=0 and be=4'b1111.
- wait_cnt:
  - Increments, saturating, each cycle if_req is high and if_gnt is low.
  - Clears on if_gnt, or whenever if_req is low.
- ISSUE:
  - mem_req=1 and mem_* are driven from the captured registers, stable for the whole state.
  - timeout_cnt increments each cycle.
  - On mem_ready: mem_rdata is captured (0 if we=1), err=0, and the state moves to RESP.
  - Else, if timeout_cnt == TIMEOUT-1: captured data = 0, err=1, and the state moves to RESP.
  - mem_req deasserts the cycle after mem_ready or timeout.
- RESP:
  - Owner's rvalid=1 for exactly one cycle.
  - rdata and rsp_err are valid this cycle; rdata holds its value until the next response.
  - Next state is IDLE, with timeout_cnt cleared.
- Latency:
  - gnt at cycle 0, mem_req from cycle 1.
  - With mem_ready at cycle k, rvalid is at cycle k+1.
  - Minimum is 3 cycles per transaction.
- Boundary cases:
  - Both requesters held: they interleave per priority/starvation rules, and no request is ever dropped.
  - Requests arriving while not in IDLE are not granted; requesters must hold req until gnt.
  - A mem_ready in the same cycle as the timeout terminal count counts as success (err=0).
  - mem_ready seen outside ISSUE is ignored.
  - Reset asserted mid-transaction aborts it silently: no rvalid is produced.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined:
  - The fixed data priority is replaced by round-robin.
  - When both request in IDLE, the requester not served last wins.
  - A single requester always wins.
  - The last-served register resets to IF, so data wins the first contested cycle.
  - wait_cnt and MAX_WAIT logic are removed.
- Undefined: fixed data priority with the MAX_WAIT starvation override, as described above.

Test Plan:
- Single fetch:
  - Stimulus: if_req with if_addr=0x100; mem_ready at cycle 1 with mem_rdata=0x00000013.
  - Response: if_gnt at cycle 0; mem_addr=0x100, mem_we=0 at cycle 1; if_rvalid with if_rdata=0x00000013 at cycle 2.
- Store:
  - Stimulus: d_req, d_we=1, d_addr=0x2004, d_wdata=0xDEADBEEF, d_be=4'b0011.
  - Response: mem_* match the captured values; d_rvalid pulses with d_rdata=0 and rsp_err=0.
- Contention:
  - Stimulus: if_req and d_req both held; mem_ready is immediate.
  - Response: data is granted first each round, and fetch is forced after 4 denied cycles.
  - Define ARB_ROUND_ROBIN_EN: grants alternate D, IF, D, IF.
- Timeout:
  - Stimulus: d_req load; mem_ready is never asserted.
  - Response: mem_req is held for 16 cycles; d_rvalid then pulses with rsp_err=1 and d_rdata=0; the state returns to IDLE.
- Slow memory:
  - Stimulus: mem_ready at cycle 5.
  - Response: mem_addr stays stable across cycles 1–5; rvalid at cycle 6; if_gnt stays low throughout even though if_req is high.
- Reset mid-ISSUE:
  - Stimulus: assert rst asynchronously between clock edges.
  - Response: mem_req drops immediately with no rvalid; after release, a new request is granted normally.
